// File: rtl/iload_server.sv
// iload_server: round-robin instruction-fetch arbiter in front of a shared single-word RAM read port.
// Per-CPU words are packed CPU i at bits [i*32 +: 32]; ramstate: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
// Optional one-entry last-fill buffer enabled by defining ILOAD_LFB_EN.
module iload_server #(
    parameter int CPUS = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*32-1:0]   iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS*32-1:0]   iload,
    input  logic                 dbusy,
    output logic                 ramREN,
    output logic [31:0]          ramaddr,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate
);
    localparam int RR_W = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state, state_next;
    logic [RR_W-1:0]   rr, rr_next;
    logic [RR_W-1:0]   sel, sel_next;
    logic [RR_W-1:0]   pick;
    logic [31:0]       req_addr, req_addr_next;
    logic              found;
    logic [CPUS-1:0]   grant;
    logic [31:0]       grant_data;
    logic [31:0]       addr_w [CPUS];
    logic [2*CPUS-1:0] dbl;
    logic [CPUS-1:0]   rot;
    logic              lfb_hit;
    logic [31:0]       lfb_word;

    function automatic logic [RR_W-1:0] wrap_add(input logic [RR_W-1:0] v, input int k);
        int t;
        t = int'(v) + k;
        if (t >= CPUS) t = t - CPUS;
        return RR_W'(t);
    endfunction

    for (genvar i = 0; i < CPUS; i++) begin : g_cpu
        assign addr_w[i]          = iaddr[i*32 +: 32];
        assign iwait[i]           = ~grant[i];
        assign iload[i*32 +: 32]  = grant[i] ? grant_data : 32'h0;
    end

    // Rotate the request vector so bit 0 is the CPU at rr; lowest set bit wins.
    always_comb begin
        dbl   = {iREN, iREN} >> rr;
        rot   = dbl[CPUS-1:0];
        found = |rot;
        pick  = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            if (rot[k]) pick = wrap_add(rr, k);
        end
    end

`ifdef ILOAD_LFB_EN
    logic        lfb_valid;
    logic [31:0] lfb_addr;
    logic [31:0] lfb_data;

    assign lfb_hit  = found && lfb_valid && (addr_w[pick] == lfb_addr);
    assign lfb_word = lfb_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            lfb_valid <= 1'b0;
            lfb_addr  <= '0;
            lfb_data  <= '0;
        end else if (state == REQ && |grant) begin
            lfb_valid <= 1'b1;
            lfb_addr  <= req_addr;
            lfb_data  <= ramload;
        end
    end
`else
    assign lfb_hit  = 1'b0;
    assign lfb_word = '0;
`endif

    always_comb begin
        state_next    = state;
        rr_next       = rr;
        sel_next      = sel;
        req_addr_next = req_addr;
        grant         = '0;
        grant_data    = '0;
        ramREN        = 1'b0;
        ramaddr       = '0;
        case (state)
            IDLE: begin
                if (lfb_hit) begin
                    grant[pick] = 1'b1;
                    grant_data  = lfb_word;
                    rr_next     = wrap_add(pick, 1);
                end else if (found) begin
                    sel_next      = pick;
                    req_addr_next = addr_w[pick];
                    state_next    = REQ;
                end
            end
            REQ: begin
                // A dropped request or a redirected address abandons the read outright.
                if (!iREN[sel] || addr_w[sel] != req_addr) begin
                    state_next = IDLE;
                end else if (!dbusy) begin
                    ramREN  = 1'b1;
                    ramaddr = req_addr;
                    if (ramstate == RAM_ACCESS) begin
                        grant[sel] = 1'b1;
                        grant_data = ramload;
                        rr_next    = wrap_add(sel, 1);
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (RST) begin
            grant      = '0;
            grant_data = '0;
            ramREN     = 1'b0;
            ramaddr    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            rr       <= '0;
            sel      <= '0;
            req_addr <= '0;
        end else begin
            state    <= state_next;
            rr       <= rr_next;
            sel      <= sel_next;
            req_addr <= req_addr_next;
        end
    end
endmodule

// File: tb/tb_iload_server.sv
// Self-checking bench for iload_server: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbitration and RAM-read rules.
module tb_iload_server;
    localparam int CPUS = 2;
`ifdef ILOAD_LFB_EN
    localparam bit LFB = 1'b1;
`else
    localparam bit LFB = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST;
    logic [CPUS-1:0]   iREN;
    logic [CPUS*32-1:0] iaddr;
    logic [CPUS-1:0]   iwait;
    logic [CPUS*32-1:0] iload;
    logic              dbusy;
    logic              ramREN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramload;
    logic [1:0]        ramstate;

    always #5 CLK = ~CLK;

    iload_server #(.CPUS(CPUS)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dbusy(dbusy), .ramREN(ramREN), .ramaddr(ramaddr), .ramload(ramload), .ramstate(ramstate)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: is a fetch outstanding, for whom, at which address, plus the fill buffer.
    int          m_rr = 0, m_sel = 0, n_rr, n_sel;
    bit          m_busy = 0, n_busy;
    logic [31:0] m_addr = '0, n_addr;
    bit          m_lv = 0, n_lv;
    logic [31:0] m_la = '0, m_ld = '0, n_la, n_ld;

    logic [CPUS-1:0]    e_iwait;
    logic [CPUS*32-1:0] e_iload;
    logic               e_ren;
    logic [31:0]        e_addr;

    int          grant_cpu[$];
    logic [31:0] grant_adr[$];
    logic [31:0] grant_dat[$];
    int          ren_cnt;

    function automatic logic [31:0] addr_of(input int c);
        return iaddr[c*32 +: 32];
    endfunction

    function automatic void model();
        e_iwait = '1; e_iload = '0; e_ren = 1'b0; e_addr = '0;
        n_rr = m_rr; n_sel = m_sel; n_busy = m_busy; n_addr = m_addr;
        n_lv = m_lv; n_la = m_la; n_ld = m_ld;
        if (RST) begin
            n_rr = 0; n_sel = 0; n_busy = 0; n_addr = '0; n_lv = 0; n_la = '0; n_ld = '0;
            return;
        end
        if (!m_busy) begin
            for (int i = 0; i < CPUS; i++) begin
                int c = (m_rr + i) % CPUS;
                if (iREN[c]) begin
                    if (LFB && m_lv && addr_of(c) == m_la) begin
                        e_iwait[c] = 1'b0;
                        e_iload[c*32 +: 32] = m_ld;
                        n_rr = (c + 1) % CPUS;
                    end else begin
                        n_busy = 1; n_sel = c; n_addr = addr_of(c);
                    end
                    break;
                end
            end
        end else if (!iREN[m_sel] || addr_of(m_sel) != m_addr) begin
            n_busy = 0;
        end else if (!dbusy) begin
            e_ren = 1'b1;
            e_addr = m_addr;
            if (ramstate == 2'd2) begin
                e_iwait[m_sel] = 1'b0;
                e_iload[m_sel*32 +: 32] = ramload;
                n_rr = (m_sel + 1) % CPUS;
                n_busy = 0;
                n_lv = 1; n_la = m_addr; n_ld = ramload;
            end
        end
    endfunction

    task automatic step();
        @(negedge CLK);
        model();
        tests++;
        assert (iwait === e_iwait) else begin
            fails++; $error("FAIL iwait observed=%b expected=%b", iwait, e_iwait);
        end
        tests++;
        assert (iload === e_iload) else begin
            fails++; $error("FAIL iload observed=%h expected=%h", iload, e_iload);
        end
        tests++;
        assert (ramREN === e_ren) else begin
            fails++; $error("FAIL ramREN observed=%b expected=%b", ramREN, e_ren);
        end
        if (e_ren) begin
            tests++;
            assert (ramaddr === e_addr) else begin
                fails++; $error("FAIL ramaddr observed=%h expected=%h", ramaddr, e_addr);
            end
        end
        if (ramREN === 1'b1) ren_cnt++;
        for (int i = 0; i < CPUS; i++) begin
            if (iwait[i] === 1'b0) begin
                grant_cpu.push_back(i);
                grant_adr.push_back(ramaddr);
                grant_dat.push_back(iload[i*32 +: 32]);
            end
        end
        @(posedge CLK);
        m_rr = n_rr; m_sel = n_sel; m_busy = n_busy; m_addr = n_addr;
        m_lv = n_lv; m_la = n_la; m_ld = n_ld;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        grant_cpu.delete(); grant_adr.delete(); grant_dat.delete(); ren_cnt = 0;
    endtask

    initial begin
        RST = 1'b1; iREN = '0; iaddr = '0; dbusy = 1'b0; ramstate = 2'd0; ramload = '0;
        clear_log();

        // Reset with both caches requesting and RAM offering ACCESS.
        iREN = 2'b11; iaddr = {32'h200, 32'h100}; ramstate = 2'd2; ramload = 32'hDEAD_BEEF;
        step(); step();
        check("rst_no_grant", grant_cpu.size(), 0);

        // Contention: grants alternate starting with CPU0.
        RST = 1'b0; clear_log();
        repeat (6) step();
        check("cont_count", grant_cpu.size(), 3);
        check("cont_cpu0", grant_cpu[0], 0);
        check("cont_cpu1", grant_cpu[1], 1);
        check("cont_cpu2", grant_cpu[2], 0);
        check("cont_addr0", grant_adr[0], 32'h100);
        check("cont_addr1", grant_adr[1], 32'h200);
        check("cont_addr2", grant_adr[2], 32'h100);

        // Single fetch with two-cycle RAM latency.
        iREN = 2'b01; iaddr = {32'h200, 32'h40}; ramstate = 2'd1; ramload = 32'h8C02_0004;
        clear_log();
        step(); step();
        ramstate = 2'd2;
        step();
        iREN = 2'b00;
        step();
        check("single_count", grant_cpu.size(), 1);
        check("single_cpu", grant_cpu[0], 0);
        check("single_addr", grant_adr[0], 32'h40);
        check("single_data", grant_dat[0], 32'h8C02_0004);
        check("single_ren", ren_cnt, 2);

        // dbusy blocks a ready ACCESS for three cycles.
        iREN = 2'b01; iaddr = {32'h200, 32'h300}; ramstate = 2'd2; ramload = 32'h0BAD_F00D;
        clear_log();
        step();
        dbusy = 1'b1;
        repeat (3) step();
        check("dbusy_nogrant", grant_cpu.size(), 0);
        check("dbusy_noren", ren_cnt, 0);
        dbusy = 1'b0;
        step();
        iREN = 2'b00;
        step();
        check("dbusy_grant", grant_cpu.size(), 1);
        check("dbusy_addr", grant_adr[0], 32'h300);

        // Redirect mid-REQ, then ERROR retries before a late ACCESS.
        iREN = 2'b01; iaddr = {32'h200, 32'h40}; ramstate = 2'd1; ramload = 32'h1234_5678;
        clear_log();
        step(); step();
        iaddr = {32'h200, 32'h80}; ramstate = 2'd2;
        step();
        check("redir_nogrant", grant_cpu.size(), 0);
        ramstate = 2'd3;
        step(); step(); step();
        ramstate = 2'd2;
        step();
        iREN = 2'b00;
        step();
        check("redir_count", grant_cpu.size(), 1);
        check("redir_addr", grant_adr[0], 32'h80);
        check("redir_data", grant_dat[0], 32'h1234_5678);
        check("redir_ren", ren_cnt, 4);

        // Same address fetched by CPU0 then CPU1: fill buffer serves CPU1 without RAM.
        RST = 1'b1; step(); RST = 1'b0;
        iREN = 2'b01; iaddr = {32'h200, 32'h40}; ramstate = 2'd2; ramload = 32'hCAFE_0040;
        step(); step();
        iREN = 2'b10; iaddr = {32'h40, 32'h40}; ramload = 32'h5555_AAAA;
        clear_log();
        step(); step();
        iREN = 2'b00;
        step();
        check("lfb_ren", ren_cnt, LFB ? 0 : 1);
        check("lfb_grants", grant_cpu.size(), LFB ? 2 : 1);
        check("lfb_data", grant_dat[0], LFB ? 32'hCAFE_0040 : 32'h5555_AAAA);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            RST = ($urandom_range(63) == 0);
            for (int c = 0; c < CPUS; c++) begin
                if ($urandom_range(3) == 0) iREN[c] = ~iREN[c];
                if ($urandom_range(7) == 0) begin
                    case ($urandom_range(3))
                        0: iaddr[c*32 +: 32] = 32'h40;
                        1: iaddr[c*32 +: 32] = 32'h80;
                        2: iaddr[c*32 +: 32] = 32'hC0;
                        default: iaddr[c*32 +: 32] = $urandom;
                    endcase
                end
            end
            dbusy = ($urandom_range(3) == 0);
            ramstate = 2'($urandom_range(3));
            ramload = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iload_server.md
# iload_server

Memory-controller side of the instruction-fetch bus: accepts `iREN`/`iaddr` requests from up to `CPUS` instruction caches, arbitrates round-robin, issues single-word RAM reads, and returns the word on `iload` with a one-cycle `iwait` drop to the winning cache. It sits between the per-core caches and the shared RAM port, yielding the RAM whenever data traffic (`dbusy`) owns it.

## Interface

- `CPUS`, 2: number of instruction-cache requesters (1..4).
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `iREN`  in  CPUS  per-cache read request; level, held until served or withdrawn.
- `iaddr`  in  CPUS x 32 (`word_t`)  per-cache word address.
- `iwait`  out  CPUS  per-cache wait; low for exactly the cycle `iload` is valid.
- `iload`  out  CPUS x 32 (`word_t`)  per-cache returned instruction word.
- `dbusy`  in  1  data side owns RAM this cycle; no instruction read may be issued or completed.
- `ramREN`  out  1  RAM read enable.
- `ramaddr`  out  32  RAM word address.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  `ramstate_t`  FREE / BUSY / ACCESS / ERROR.

## Operation

- States: IDLE, REQ.
- Round-robin pointer `rr` (log2 CPUS bits, min 1): next CPU to consider first. Reset 0.
- IDLE: scan `iREN` starting at `rr`, wrapping; first asserted index becomes `sel`; latch `sel` and `iaddr[sel]` into `req_addr`; go to REQ. No request: stay IDLE.
- REQ, `dbusy`=0: `ramREN`=1, `ramaddr`=`req_addr`.
  - `ramstate`==ACCESS: `iwait[sel]`=0, `iload[sel]`=`ramload` (combinational, same cycle); `rr` <= `sel`+1 mod CPUS; go to IDLE.
  - BUSY/FREE: hold.
  - ERROR: hold, `ramREN` stays high (retry); no completion.
- REQ, `dbusy`=1: `ramREN`=0, no completion even if `ramstate`==ACCESS; stay REQ.
- Withdrawal: in REQ, if `iREN[sel]`=0 or `iaddr[sel]`!=`req_addr` (branch redirect), `ramREN`=0 that cycle, go to IDLE, `rr` unchanged; no `iwait` drop.
- Non-selected CPUs: `iwait`=1 always; `iload`=0.
- Outputs in IDLE: `iwait`=all 1, `iload`=0, `ramREN`=0, `ramaddr`=0.
- Reset: state IDLE, `rr`=0, `req_addr`=0; outputs at IDLE values the cycle `RST` is high, regardless of a pending completion.

## Timing

- Request visible at edge N (IDLE) -> REQ from N+1; earliest completion in cycle N+1 if RAM returns ACCESS combinationally; each extra RAM latency cycle adds one.
- One completion max per cycle; at least one IDLE cycle between consecutive grants (throughput one word per 2 cycles at zero RAM latency).
- Fairness: with all `CPUS` requesting continuously, each is served once per `CPUS` grants.
- Simultaneous withdrawal and ACCESS in one cycle: withdrawal wins, no `iwait` drop.
- `dbusy` high indefinitely: REQ holds, no deadlock when it falls.

## Configuration

- `ILOAD_LFB_EN` defined: one-entry last-fill buffer (valid, addr, data), updated on every completion, cleared on reset. In IDLE, if the arbitrated `iaddr[sel]` equals buffer addr and valid: `iwait[sel]`=0, `iload[sel]`=buffer data that cycle, `rr` advances, no RAM access, stay IDLE. Buffer is never invalidated by data writes (instruction memory is read-only to this block).
- Undefined: no buffer; every request goes through REQ.

## Test plan

- Reset: `RST`=1 with `iREN`=2'b11 -> `iwait`=2'b11, `ramREN`=0, `iload`=0 both; after release first grant to CPU0.
- Single fetch, CPUS=2, `iREN`=2'b01, `iaddr[0]`=0x40, RAM 2-cycle latency returning 0x8C020004 -> `ramaddr`=0x40, `iwait[0]` low one cycle with `iload[0]`=0x8C020004, `iwait[1]` stays 1.
- Contention: both request continuously, addresses 0x100/0x200 -> grants alternate CPU0, CPU1, CPU0; `ramaddr` sequence 0x100, 0x200, 0x100.
- `dbusy` high for 3 cycles during REQ with `ramstate`=ACCESS -> `ramREN`=0, no `iwait` drop; completion first cycle after `dbusy` falls.
- Redirect: CPU0 changes `iaddr` 0x40 -> 0x80 mid-REQ -> no completion for 0x40, next IDLE re-latches 0x80 and serves it; ERROR for 2 cycles -> `ramREN` held, served on later ACCESS.
- `ILOAD_LFB_EN`: fetch 0x40 from CPU0, then CPU1 requests 0x40 -> `iwait[1]` low in the IDLE cycle, `ramREN` never asserted for it; without macro, RAM read issued.
